// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and helpers for the sequential ALU.
//   alu_op_t     - 4-bit opcode; codes above OP_REMU are undefined.
//   state_t      - controller states (IDLE, BUSY, DONE).
//   is_iterative - op runs on the multi-cycle shift/subtract datapath.
//   is_divide    - op is DIVU or REMU (needs the divide-by-zero bypass).
//   is_defined   - raw 4-bit code maps onto a defined opcode.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REMU = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_LAST = 4'd12;

    function automatic logic is_iterative(input alu_op_t op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_divide(input alu_op_t op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_defined(input logic [3:0] code);
        return code <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_seq_base.sv
// alu_seq_base: purely combinational single-cycle RV32I ALU operations.
// Ports:
//   op     in  4      opcode (alu_op_t encoding)
//   a, b   in  WIDTH  operands; shifts use b[SHW-1:0] only
//   result out WIDTH  result; 0 for MUL/DIVU/REMU and undefined codes
import alu_seq_pkg::*;

module alu_seq_base #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    logic [SHW-1:0] shamt;
    logic           lt_signed;
    logic           lt_unsigned;

    assign shamt       = b[SHW-1:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        result = '0;
        case (alu_op_t'(op))
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the RV32I/M datapath.
// Single-cycle ops come from alu_seq_base and are registered; MUL (low half),
// DIVU and REMU run one bit per cycle on a shift-add / restoring-divide
// datapath.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake; in_ready is high only in IDLE
//   op, a, b            opcode and operands, sampled at accept only
//   out_valid, out_ready result handshake; out_valid is high only in DONE
//   result, zero        registered result and (result == 0)
//   illegal             op was an undefined code (qualified by out_valid)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Once out_valid rises, result/zero/illegal are held until that edge;
// the block never accepts in the same cycle it delivers, so ops never overlap.
import alu_seq_pkg::*;

module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    state_t         state, state_d;
    logic [SHW-1:0] cnt, cnt_d;

    alu_op_t        op_in;
    logic           accept;
    logic           b_is_zero;
    logic           start_iter;
    logic [WIDTH-1:0] base_res;
    logic [WIDTH-1:0] quick_res;

    // Iteration registers
    alu_op_t          op_q;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo, dvs;

    // Output registers
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    assign op_in     = alu_op_t'(op);
    assign accept    = in_valid && in_ready;
    assign b_is_zero = (b == '0);
    // Divide by zero skips the iterative path and answers in one cycle.
    assign start_iter = is_iterative(op_in) && !(is_divide(op_in) && b_is_zero);

    alu_seq_base #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_base (
        .op    (op),
        .a     (a),
        .b     (b),
        .result(base_res)
    );

    always_comb begin
        quick_res = base_res;
        if (!is_defined(op)) begin
            quick_res = '0;
        end else if (b_is_zero && (op_in == OP_DIVU)) begin
            quick_res = '1;
        end else if (b_is_zero && (op_in == OP_REMU)) begin
            quick_res = a;
        end
    end

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (start_iter) begin
                        state_d = BUSY;
                        cnt_d   = SHW'(WIDTH - 1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- iteration step ----------------
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] final_res;

    always_comb begin
        acc_n   = acc + (mplier[0] ? mcand : '0);
        // Restoring divide: bring the next dividend bit (MSB first) into the
        // partial remainder and keep the subtraction only if it did not borrow.
        shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs};
        qbit    = ~trial[WIDTH+1];
        rem_n   = qbit ? trial[WIDTH:0] : shifted;
        // The dividend register doubles as the quotient register.
        quo_n   = {quo[WIDTH-2:0], qbit};
        case (op_q)
            OP_MUL:  final_res = acc_n;
            OP_DIVU: final_res = quo_n;
            default: final_res = rem_n[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_ADD;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else if (accept) begin
            op_q   <= op_in;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            rem    <= '0;
            quo    <= a;
            dvs    <= b;
            if (!start_iter) begin
                result_q  <= quick_res;
                zero_q    <= (quick_res == '0);
                illegal_q <= !is_defined(op);
            end
        end else if (state == BUSY) begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_n;
            quo    <= quo_n;
            if (cnt == '0) begin
                result_q  <= final_res;
                zero_q    <= (final_res == '0);
                illegal_q <= 1'b0;
            end
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=32.
import alu_seq_pkg::*;

module tb_alu_seq;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .illegal  (illegal)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one op, measures edges from accept to out_valid (1 = next cycle),
    // optionally holds out_ready low for `hold` cycles, then delivers.
    task automatic run_op(input string tag, input logic [3:0] op_v,
                          input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic [W-1:0] exp_res, input logic exp_ill,
                          input int exp_lat, input int hold);
        int   lat;
        logic saw_ready;
        logic unstable;
        logic [W-1:0] r0;
        logic z0;
        logic [W-1:0] exp_v;
        exp_q.push_back(exp_res);
        @(negedge clk);
        check_eq({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        op        = op_v;
        a         = a_v;
        b         = b_v;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands after accept; they must not affect the result.
        op = 4'($urandom_range(0, 15));
        a  = $urandom;
        b  = $urandom;
        lat       = 1;
        saw_ready = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (in_ready) saw_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_ready_busy"}, 32'(saw_ready), 32'd0);
        exp_v = exp_q.pop_front();
        check_eq({tag, "_result"}, result, exp_v);
        check_eq({tag, "_zero"}, 32'(zero), 32'(exp_v == '0));
        check_eq({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        if (hold > 0) begin
            r0       = result;
            z0       = zero;
            unstable = 1'b0;
            for (int i = 0; i < hold; i++) begin
                in_valid = (i % 2 == 0);
                op       = OP_ADD;
                @(negedge clk);
                if (result !== r0 || zero !== z0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                    unstable = 1'b1;
            end
            in_valid = 1'b0;
            check_eq({tag, "_bp_stable"}, 32'(unstable), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    logic bad;

    initial begin
        // Reset with a valid op held on the inputs.
        reset     = 1'b1;
        in_valid  = 1'b1;
        op        = OP_ADD;
        a         = 32'd1;
        b         = 32'd2;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_zero", 32'(zero), 32'd1);
        check_eq("rst_illegal", 32'(illegal), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("rst_first_accept_valid", 32'(out_valid), 32'd1);
        check_eq("rst_first_accept_result", result, 32'd3);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("rst_first_deliver", 32'(out_valid), 32'd0);

        // Single-cycle ops
        run_op("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h1,          32'h0,          1'b0, 1, 0);
        run_op("sub_neg",  OP_SUB,  32'h5,         32'h7,          32'hFFFF_FFFE,  1'b0, 1, 0);
        run_op("and",      OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1, 0);
        run_op("or",       OP_OR,   32'hF000_0001, 32'h0000_0F00,  32'hF000_0F01,  1'b0, 1, 0);
        run_op("xor",      OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000,  32'h5555_5555,  1'b0, 1, 0);
        run_op("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h1,          32'h1,          1'b0, 1, 0);
        run_op("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1,          32'h0,          1'b0, 1, 0);
        run_op("sll",      OP_SLL,  32'h1,         32'h25,         32'h20,         1'b0, 1, 0);
        run_op("srl",      OP_SRL,  32'h8000_0000, 32'h4,          32'h0800_0000,  1'b0, 1, 0);
        run_op("sra",      OP_SRA,  32'h8000_0000, 32'h21,         32'hC000_0000,  1'b0, 1, 0);

        // Iterative ops
        run_op("mul_a",    OP_MUL,  32'h0001_0001, 32'h0001_0001,  32'h0002_0001,  1'b0, 33, 0);
        run_op("mul_ones", OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 33, 0);
        run_op("mul_zero", OP_MUL,  32'h1234_5678, 32'h0,          32'h0,          1'b0, 33, 0);
        run_op("divu",     OP_DIVU, 32'd100,       32'd7,          32'd14,         1'b0, 33, 0);
        run_op("remu",     OP_REMU, 32'd100,       32'd7,          32'd2,          1'b0, 33, 0);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h1,          32'hFFFF_FFFF,  1'b0, 33, 0);
        run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10,         32'hF,          1'b0, 33, 0);
        run_op("divu_lt",  OP_DIVU, 32'd7,         32'd100,        32'd0,          1'b0, 33, 0);
        run_op("divu_z",   OP_DIVU, 32'd5,         32'd0,          32'hFFFF_FFFF,  1'b0, 1, 0);
        run_op("remu_z",   OP_REMU, 32'd5,         32'd0,          32'd5,          1'b0, 1, 0);

        // Undefined opcodes
        run_op("ill_f",    4'hF,    32'h1234,      32'h5678,       32'h0,          1'b1, 1, 0);
        run_op("ill_d",    4'hD,    32'hFFFF_FFFF, 32'h1,          32'h0,          1'b1, 1, 0);

        // Backpressure on an iterative and a single-cycle op
        run_op("bp_divu",  OP_DIVU, 32'd100,       32'd7,          32'd14,         1'b0, 33, 10);
        run_op("bp_add",   OP_ADD,  32'd40,        32'd2,          32'd42,         1'b0, 1, 10);

        // Reset in the middle of a DIVU
        @(negedge clk);
        op        = OP_DIVU;
        a         = 32'd1000;
        b         = 32'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        check_eq("abort_result", result, 32'd0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        check_eq("abort_no_output", 32'(bad), 32'd0);
        run_op("post_abort_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
